if_stage: RTL

- Instruction-fetch stage, directly upstream of the decode stage.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request channel, with variable response latency.
- Buffers returned instructions in a small FIFO and presents {inst, pc} to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushes the FIFO and squashes in-flight fetches.

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage_fifo.sv | 72 +++++++
 rtl/if_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_stage_pkg;

    localparam int          WORD_W        = 32;
    localparam logic [31:0] IF_RESET_PC   = 32'h1C00_0000;
    localparam int          IF_FIFO_DEPTH = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t inst;
        word_t pc;
    } fetch_entry_t;

    function automatic word_t align_word(input word_t addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_fifo.sv
// Register-based synchronous FIFO with flush; head is read straight from storage flops.
module if_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited fetches, buffers
// returned words and hands {inst, pc} to decode; redirects squash in-flight work.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IF_RESET_PC,
    parameter int          FIFO_DEPTH = IF_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    word_t         pc_q, pc_d;
    word_t         if_pc_q, if_pc_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] outstanding, buf_count;
    logic          pcq_full, pcq_empty, buf_full, buf_empty;
    word_t         pcq_head;
    fetch_entry_t  buf_head, buf_in;
    logic          req_fire, resp_ok, resp_keep, pop, credit_ok;

    assign if_valid = !buf_empty && !redirect;
    assign pop      = if_valid && id_ready;

    // Credits cover in-flight plus buffered fetches; a slot freed by this cycle's
    // pop may be reissued at once, which sustains one fetch per cycle.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, buf_count})
                     < ((CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop});

    assign imem_req_valid = !rst && !redirect && !pcq_full && credit_ok;
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_ok   = imem_resp_valid && !pcq_empty && !rst;
    assign resp_keep = resp_ok && !redirect && (drop_q == '0) && (!buf_full || pop);
    assign buf_in    = '{inst: imem_resp_data, pc: pcq_head};

    assign if_inst = if_valid ? buf_head.inst : '0;
    assign if_pc   = if_valid ? buf_head.pc   : if_pc_q;

    always_comb begin
        pc_d    = pc_q;
        drop_d  = drop_q;
        if_pc_d = if_pc;
        if (redirect) begin
            pc_d   = align_word(redirect_pc);
            // No fetch issues this cycle, so whatever is still outstanding afterwards is stale.
            drop_d = outstanding - CW'(resp_ok);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (resp_ok && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            drop_q  <= '0;
            if_pc_q <= '0;
        end else begin
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            if_pc_q <= if_pc_d;
        end
    end

    if_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_keep),
        .push_data (buf_in),
        .pop       (pop),
        .flush     (redirect),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // Not flushed on redirect: squashed responses still retire their PC entry.
    if_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (resp_ok),
        .flush     (1'b0),
        .head      (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (outstanding)
    );

endmodule
